// File: rtl/seg_anim_pkg.sv
// seg_anim_pkg: shared types and constants for the seven-segment frame sequencer.
// Frame index width, last frame and loop counter width live here.
package seg_anim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int COUNT_W = 3;
  localparam int LOOP_W  = 4;

  localparam logic [COUNT_W-1:0] LAST_FRAME  = 3'd7;
  localparam logic [COUNT_W-1:0] FIRST_FRAME = 3'd0;

  function automatic logic [COUNT_W-1:0] step_frame(
    input logic [COUNT_W-1:0] cur,
    input logic               rev
  );
    if (rev) begin
      step_frame = cur - COUNT_W'(1);
    end else begin
      step_frame = cur + COUNT_W'(1);
    end
  endfunction

  function automatic logic is_wrap(
    input logic [COUNT_W-1:0] cur,
    input logic               rev
  );
    if (rev) begin
      is_wrap = (cur == FIRST_FRAME);
    end else begin
      is_wrap = (cur == LAST_FRAME);
    end
  endfunction

endpackage

// File: rtl/seg_anim_sequencer_div.sv
// frame_tick_div: programmable prescaler producing one frame tick per i_div+1
// enabled cycles; the count freezes while i_en is low.
module frame_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_hit;
  logic             w_tick;

  assign w_hit  = (r_cnt == i_div);
  assign w_tick = w_hit & i_en & ~i_clr;
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seg_anim_sequencer.sv
// seg_anim_sequencer: frame index sequencer feeding the seven-segment decoder.
// Optional reverse play is enabled by defining SEG_ANIM_REVERSE_EN.
module seg_anim_sequencer
  import seg_anim_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_enable,
  input  logic [DIV_W-1:0]   i_div,
  input  logic [LOOP_W-1:0]  i_loops,
`ifdef SEG_ANIM_REVERSE_EN
  input  logic               i_reverse,
`endif
  output logic [COUNT_W-1:0] o_count,
  output logic               o_step,
  output logic               o_busy,
  output logic               o_done
);

  state_t r_state;
  state_t w_state_nxt;

  logic [DIV_W-1:0]   r_div_q;
  logic [LOOP_W-1:0]  r_loops_q;
  logic [LOOP_W-1:0]  r_loop;
  logic [COUNT_W-1:0] r_count;
  logic               r_step;
  logic               r_done;

  logic               w_rev;
  logic               w_clr;
  logic               w_tick;
  logic               w_go;
  logic               w_wrap;
  logic               w_last;
  logic               w_finish;
  logic               w_busy;
  logic [LOOP_W-1:0]  w_loop_inc;
  logic [COUNT_W-1:0] w_cnt_nxt;
  logic [COUNT_W-1:0] w_cnt_load;

`ifdef SEG_ANIM_REVERSE_EN
  logic r_rev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rev <= 1'b0;
    end else if (w_go) begin
      r_rev <= i_reverse;
    end
  end

  assign w_rev      = r_rev;
  assign w_cnt_load = i_reverse ? LAST_FRAME : FIRST_FRAME;
`else
  assign w_rev      = 1'b0;
  assign w_cnt_load = FIRST_FRAME;
`endif

  // Prescaler is held clear whenever we are not actively running.
  assign w_clr = (r_state != RUN) | i_stop;

  frame_tick_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_en   (i_enable),
    .i_div  (r_div_q),
    .o_tick (w_tick)
  );

  assign w_go       = (r_state == IDLE) & i_start & ~i_stop;
  assign w_wrap     = is_wrap(r_count, w_rev);
  assign w_cnt_nxt  = step_frame(r_count, w_rev);
  assign w_loop_inc = r_loop + LOOP_W'(1);
  assign w_last     = w_wrap & (r_loops_q != '0) & (w_loop_inc == r_loops_q);
  assign w_finish   = w_tick & w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_stop || w_finish) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    unique case (r_state)
      IDLE:    w_busy = 1'b0;
      RUN:     w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_q   <= '0;
      r_loops_q <= '0;
    end else if (w_go) begin
      r_div_q   <= i_div;
      r_loops_q <= i_loops;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= FIRST_FRAME;
      r_loop  <= '0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_loop  <= '0;
          r_count <= w_go ? w_cnt_load : FIRST_FRAME;
        end
        RUN: begin
          if (i_stop) begin
            r_count <= FIRST_FRAME;
            r_loop  <= '0;
          end else if (w_tick) begin
            r_step <= 1'b1;
            if (w_last) begin
              // Completion always parks the index at 0, also in reverse play.
              r_count <= FIRST_FRAME;
              r_loop  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_count <= w_cnt_nxt;
              if (w_wrap) begin
                r_loop <= w_loop_inc;
              end
            end
          end
        end
        default: begin
          r_count <= FIRST_FRAME;
          r_loop  <= '0;
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_step  = r_step;
  assign o_done  = r_done;
  assign o_busy  = w_busy;

endmodule

// File: tb/tb_seg_anim_sequencer.sv
// tb_seg_anim_sequencer: directed checks of the frame sequencer.
// Reverse-play vectors run only when SEG_ANIM_REVERSE_EN is defined.
module tb_seg_anim_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, en;
  logic [15:0] div;
  logic [3:0]  loops;
  logic        rev;
  logic [2:0]  count;
  logic        step, busy, done;

  int n_tot = 0;
  int n_bad = 0;
  int steps, dones, done_at;

  always #5 clk = ~clk;

  seg_anim_sequencer #(.DIV_W(16)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_stop   (stop),
    .i_enable (en),
    .i_div    (div),
    .i_loops  (loops),
`ifdef SEG_ANIM_REVERSE_EN
    .i_reverse(rev),
`endif
    .o_count  (count),
    .o_step   (step),
    .o_busy   (busy),
    .o_done   (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] d, input logic [3:0] l);
    div   = d;
    loops = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; en = 1; div = 0; loops = 0; rev = 0;
    repeat (3) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();

    // Basic run: div=3, one loop, 32 cycles to done
    go(16'd3, 4'd1);
    chk("basic_busy0", 32'(busy), 1);
    chk("basic_cnt0", 32'(count), 0);
    chk("basic_step0", 32'(step), 0);
    steps = 0; dones = 0; done_at = -1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("basic_cnt_k%0d", k), 32'(count), 32'((k / 4) % 8));
      chk($sformatf("basic_step_k%0d", k), 32'(step), 32'(k % 4 == 0));
      if (step) steps++;
      if (done) begin dones++; done_at = k; end
    end
    chk("basic_steps", 32'(steps), 8);
    chk("basic_dones", 32'(dones), 1);
    chk("basic_done_at", 32'(done_at), 32);
    chk("basic_busy_end", 32'(busy), 0);
    tick();
    chk("basic_done_1w", 32'(done), 0);

    // Reset mid-run at frame 5
    go(16'd3, 4'd0);
    repeat (20) tick();
    chk("mrst_pre_cnt", 32'(count), 5);
    #2 rst = 1'b1;
    #1;
    chk("mrst_cnt", 32'(count), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_step", 32'(step), 0);
    #1 rst = 1'b0;
    repeat (6) tick();
    chk("mrst_after_cnt", 32'(count), 0);
    chk("mrst_after_busy", 32'(busy), 0);

    // Multi-loop with div=0: one done at the third wrap
    go(16'd0, 4'd3);
    dones = 0; done_at = -1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk($sformatf("ml_cnt_k%0d", k), 32'(count), 32'(k % 8));
      chk($sformatf("ml_busy_k%0d", k), 32'(busy), 32'(k < 24));
      if (done) begin dones++; done_at = k; end
    end
    chk("ml_dones", 32'(dones), 1);
    chk("ml_done_at", 32'(done_at), 24);

    // Pause at frame 4 with prescaler mid-phase
    go(16'd1, 4'd0);
    repeat (9) tick();
    chk("pause_pre_cnt", 32'(count), 4);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("pause_cnt", 32'(count), 4);
      chk("pause_step", 32'(step), 0);
      chk("pause_busy", 32'(busy), 1);
    end
    en = 1'b1;
    tick();
    chk("resume_cnt", 32'(count), 5);
    chk("resume_step", 32'(step), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pause_stop_busy", 32'(busy), 0);

    // Abort at frame 6, then precedence checks
    go(16'd0, 4'd0);
    repeat (6) tick();
    chk("abort_pre_cnt", 32'(count), 6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cnt", 32'(count), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_step", 32'(step), 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("both_busy", 32'(busy), 0);
    tick();
    chk("both_busy2", 32'(busy), 0);

    // Restart during RUN ignored; div/loops changes ignored
    go(16'd1, 4'd1);
    div = 16'd5; loops = 4'd0;
    dones = 0; done_at = -1;
    for (int k = 1; k <= 16; k++) begin
      start = (k == 4);
      tick();
      chk($sformatf("ign_cnt_k%0d", k), 32'(count), 32'((k / 2) % 8));
      if (done) begin dones++; done_at = k; end
    end
    start = 1'b0;
    chk("ign_dones", 32'(dones), 1);
    chk("ign_done_at", 32'(done_at), 16);
    chk("ign_busy_end", 32'(busy), 0);

`ifdef SEG_ANIM_REVERSE_EN
    rev = 1'b1;
    go(16'd0, 4'd2);
    rev = 1'b0;
    chk("rev_cnt0", 32'(count), 7);
    dones = 0; done_at = -1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("rev_cnt_k%0d", k), 32'(count),
          (k == 16) ? 32'd0 : 32'(7 - (k % 8)));
      if (done) begin dones++; done_at = k; end
    end
    chk("rev_dones", 32'(dones), 1);
    chk("rev_done_at", 32'(done_at), 16);
    chk("rev_busy_end", 32'(busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_anim_sequencer.md
# seg_anim_sequencer

Frame sequencer that generates the 3-bit frame index consumed by the seven-segment pattern decoders. It divides the system clock into a programmable frame rate and steps the index 0..7. It repeats the sequence for a programmable number of loops, then reports completion. Sits directly upstream of the pattern decoder: o_count drives the decoder's i_count.

## Interface
Parameters:
- DIV_W, 16, width of the frame-period divider.

Ports:
- i_clk  input  1  system clock; all state changes on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  one-cycle start request; honoured only in IDLE.
- i_stop  input  1  abort; returns to IDLE from any state.
- i_enable  input  1  prescaler advance enable; low freezes animation in place.
- i_div  input  DIV_W  frame period minus one, in i_clk cycles; latched at start.
- i_loops  input  4  number of full 0..7 passes; 0 = run until i_stop.
- o_count  output  3  current frame index to the pattern decoder.
- o_step  output  1  one-cycle pulse in the cycle o_count changes.
- o_busy  output  1  high in RUN.
- o_done  output  1  one-cycle pulse on natural completion (not on abort).

## Operation
- States: IDLE, RUN. Encoded in the shared package.
- IDLE: o_count=0, prescaler=0, loop counter=0, o_busy=0.
- IDLE & i_start & !i_stop -> RUN. Latch i_div into div_q and i_loops into loops_q. o_count stays 0.
- RUN: the prescaler counts up while i_enable=1. When it equals div_q and i_enable=1:
  - a frame tick occurs and the prescaler clears;
  - o_count increments modulo 8;
  - o_step pulses.
- Wrap (tick with o_count=7):
  - o_count goes to 0 and the loop counter increments.
  - If loops_q!=0 and the incremented loop count equals loops_q: go to IDLE and pulse o_done in the same cycle as the wrap's o_step.
  - Otherwise stay in RUN.
- i_enable=0 in RUN: prescaler, o_count and loop counter hold. No o_step. o_busy stays 1.
- i_stop in RUN: next state IDLE, o_count=0, no o_done, no o_step.
- Simultaneous i_start & i_stop in IDLE: stop wins, remain IDLE.
- i_start in RUN: ignored. i_div/i_loops changes during RUN: ignored until the next start.
- Loop counter width 4. With loops_q=0 it may wrap freely and never terminates the run.

## Timing
- Reset values: o_count=0, o_step=0, o_busy=0, o_done=0, state IDLE, all counters 0.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous). Resume requires a new i_start.
- i_start sampled at edge N: o_busy=1 after edge N.
- With i_enable held high, the first o_count change (0->1) occurs at edge N+div_q+1, then every div_q+1 cycles.
- i_div=0: o_count steps every cycle.
- o_step and o_done are registered, aligned with the o_count update, one cycle wide.
- A full run with i_loops=L and i_enable held high lasts 8*L*(div_q+1) cycles from start to the o_done edge.
- o_count is registered and glitch-free, so it is safe to feed the combinational decoder directly.

## Configuration
- SEG_ANIM_REVERSE_EN defined:
  - adds input port i_reverse (1 bit), latched at start;
  - when the latched value is 1, o_count starts at 7, decrements each tick, and wraps 0->7;
  - the wrap event (loop count, o_done) is the 0->7 transition;
  - IDLE value stays 0, and o_count is loaded with 7 on the start edge.
- SEG_ANIM_REVERSE_EN undefined: no i_reverse port, up-count only, identical behaviour otherwise.

## Structure
- Shared package seg_anim_pkg:
  - state enum {IDLE, RUN};
  - COUNT_W=3;
  - LAST_FRAME=3'd7;
  - LOOP_W=4.
- One sub-module, frame_tick_div:
  - inputs i_clk, i_rst, i_clr, i_en, i_div;
  - output o_tick;
  - holds the DIV_W prescaler.
- The sequencer owns the FSM, o_count, the loop counter, and the output pulse registers.

## Test plan
- Reset mid-run: i_div=3, i_loops=0, start, assert i_rst at frame 5 -> all outputs 0 immediately; after release, o_count stays 0 until the next i_start.
- Basic run: i_div=3, i_loops=1, i_enable=1, pulse i_start -> o_count 0..7, each frame held 4 cycles, 8 o_step pulses. o_done pulses at cycle 32 after start, coincident with o_count 7->0. o_busy then 0.
- Multi-loop with i_div=0: i_loops=3 -> o_count steps every cycle for 24 cycles, exactly one o_done at the third wrap, no o_done at the first two wraps.
- Pause: i_div=1, i_enable low for 10 cycles while o_count=4 -> o_count holds 4, no o_step, o_busy=1. On resume the remaining prescaler phase completes before the step to 5.
- Abort and precedence: stop mid-run at o_count=6 -> IDLE next cycle, o_count=0, no o_done. Then simultaneous i_start & i_stop in IDLE -> stays IDLE. Then i_start during RUN -> ignored, sequence unaffected.
- With SEG_ANIM_REVERSE_EN: i_reverse=1, i_div=0, i_loops=2 -> o_count 7,6,...,0,7,...,0. o_done on the second 0->7 wrap, after which o_count=0.
